// File: rtl/lsu_mem_port_if.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_mem_port_if
//  Brief    : Load/store request, data-memory beat and completion signals
//             shared by the pipeline, lsu_mem_port and the data memory.
//  Revision : 1.0 - initial release
// ============================================================================
interface lsu_mem_port_if;
  // EX/MEM-stage request
  logic        MemRead;
  logic        MemWrite;
  logic [3:0]  BE;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  // Data-memory beat channel
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  // Completion back to the pipeline
  logic        stall;
  logic        done;
  logic [31:0] rdata;
  logic        bus_err;
  logic        misalign_err;

  // Responder side (lsu_mem_port)
  modport slave (
    input  MemRead, MemWrite, BE, funct3, addr, wdata,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ready, mem_rdata,
    output stall, done, rdata, bus_err, misalign_err
  );

  // Requester / memory side
  modport master (
    output MemRead, MemWrite, BE, funct3, addr, wdata,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ready, mem_rdata,
    input  stall, done, rdata, bus_err, misalign_err
  );
endinterface
`default_nettype wire

// File: rtl/lsu_mem_port.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_mem_port
//  Brief    : Turns one EX/MEM load/store into one or two word-aligned
//             data-memory beats, lane-aligns store data, extends load data
//             and stalls the pipeline until the access completes.
//  Options  : LSU_MISALIGN_SPLIT_EN - when defined, accesses that cross a
//             word boundary are issued as two beats; when undefined they are
//             rejected with a misalign_err pulse and no beat.
//  Revision : 1.0 - initial release
// ============================================================================
module lsu_mem_port #(
  parameter int MAX_WAIT = 15
) (
  input  logic           CLK,
  input  logic           RST,
  lsu_mem_port_if.slave  bus
);

  localparam int c_wait_w = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [c_wait_w-1:0] c_wait_max = c_wait_w'(MAX_WAIT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    ACC1 = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t r_state, n_state;

  // Access context captured at start
  logic                r_is_load, n_is_load;
  logic [3:0]          r_be,      n_be;
  logic                r_zext,    n_zext;
  logic [1:0]          r_off,     n_off;
  logic [c_wait_w-1:0] r_wait,    n_wait;

  // Registered beat and completion outputs
  logic        r_mem_req,   n_mem_req;
  logic        r_mem_we,    n_mem_we;
  logic [31:0] r_mem_addr,  n_mem_addr;
  logic [3:0]  r_mem_be,    n_mem_be;
  logic [31:0] r_mem_wdata, n_mem_wdata;
  logic        r_done,      n_done;
  logic [31:0] r_rdata,     n_rdata;
  logic        r_bus_err,   n_bus_err;
  logic        r_misalign,  n_misalign;

  // Request decode
  logic        w_start;
  logic [1:0]  w_off;
  logic [7:0]  w_lanes;
  logic        w_split;
  logic        w_unused;

`ifdef LSU_MISALIGN_SPLIT_EN
  // Second-beat context: upper lanes, upper write data, first-beat read data
  logic [3:0]  r_be_hi,    n_be_hi;
  logic [31:0] r_wdata_hi, n_wdata_hi;
  logic [31:0] r_lo,       n_lo;
  logic [63:0] w_shifted;
`else
  logic [31:0] w_shifted;
`endif

  // Select the accessed bytes out of the (up to) two fetched words and extend
  function automatic logic [31:0] f_extend(
    input logic [63:0] pair,
    input logic [1:0]  off,
    input logic [3:0]  be,
    input logic        zext
  );
    logic [31:0] sh;
    logic [31:0] mask;
    logic [31:0] v;
    logic [31:0] res;
    sh   = 32'(pair >> {off, 3'b000});
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    v    = sh & mask;
    case (be)
      4'b0001: res = {{24{v[7]  & ~zext}}, v[7:0]};
      4'b0011: res = {{16{v[15] & ~zext}}, v[15:0]};
      default: res = v;
    endcase
    return res;
  endfunction

  // Request decode: byte offset, lane map and word-crossing detection
  always_comb begin
    w_start = (bus.MemRead | bus.MemWrite) & (r_state == IDLE);
    w_off   = bus.addr[1:0];
    w_lanes = {4'b0000, bus.BE} << w_off;
    w_split = |w_lanes[7:4];
`ifdef LSU_MISALIGN_SPLIT_EN
    w_shifted = {32'h0, bus.wdata} << {w_off, 3'b000};
`else
    w_shifted = bus.wdata << {w_off, 3'b000};
`endif
  end

  // funct3[1:0] carries the size, which BE already encodes
  assign w_unused = ^bus.funct3[1:0];

  // Next-state and next-output logic
  always_comb begin
    n_state     = r_state;
    n_is_load   = r_is_load;
    n_be        = r_be;
    n_zext      = r_zext;
    n_off       = r_off;
    n_wait      = r_wait;
    n_mem_req   = 1'b0;
    n_mem_we    = r_mem_we;
    n_mem_addr  = r_mem_addr;
    n_mem_be    = r_mem_be;
    n_mem_wdata = r_mem_wdata;
    n_done      = 1'b0;
    n_rdata     = 32'h0;
    n_bus_err   = 1'b0;
    n_misalign  = 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
    n_be_hi     = r_be_hi;
    n_wdata_hi  = r_wdata_hi;
    n_lo        = r_lo;
`endif

    case (r_state)
      IDLE: begin
        if (w_start) begin
          n_is_load = bus.MemRead;
          n_be      = bus.BE;
          n_zext    = bus.funct3[2];
          n_off     = w_off;
          n_wait    = '0;
`ifdef LSU_MISALIGN_SPLIT_EN
          n_be_hi     = w_lanes[7:4];
          n_wdata_hi  = w_shifted[63:32];
          n_state     = ACC0;
          n_mem_req   = 1'b1;
          n_mem_we    = bus.MemWrite;
          n_mem_addr  = {bus.addr[31:2], 2'b00};
          n_mem_be    = w_lanes[3:0];
          n_mem_wdata = w_shifted[31:0];
`else
          if (w_split) begin
            // Word-crossing access without split support: reject, no beat
            n_state    = DONE;
            n_done     = 1'b1;
            n_misalign = 1'b1;
          end else begin
            n_state     = ACC0;
            n_mem_req   = 1'b1;
            n_mem_we    = bus.MemWrite;
            n_mem_addr  = {bus.addr[31:2], 2'b00};
            n_mem_be    = w_lanes[3:0];
            n_mem_wdata = w_shifted[31:0];
          end
`endif
        end
      end

      ACC0: begin
        if (bus.mem_ready) begin
          n_wait = '0;
`ifdef LSU_MISALIGN_SPLIT_EN
          if (r_be_hi != 4'b0000) begin
            n_lo        = bus.mem_rdata;
            n_state     = ACC1;
            n_mem_req   = 1'b1;
            n_mem_addr  = r_mem_addr + 32'd4;
            n_mem_be    = r_be_hi;
            n_mem_wdata = r_wdata_hi;
          end else begin
            n_state = DONE;
            n_done  = 1'b1;
            n_rdata = r_is_load ? f_extend({32'h0, bus.mem_rdata}, r_off, r_be, r_zext) : 32'h0;
          end
`else
          n_state = DONE;
          n_done  = 1'b1;
          n_rdata = r_is_load ? f_extend({32'h0, bus.mem_rdata}, r_off, r_be, r_zext) : 32'h0;
`endif
        end else if (r_wait == c_wait_max) begin
          // Memory never answered: abandon the beat
          n_state   = DONE;
          n_done    = 1'b1;
          n_bus_err = 1'b1;
          n_wait    = '0;
        end else begin
          n_wait    = r_wait + 1'b1;
          n_mem_req = 1'b1;
        end
      end

`ifdef LSU_MISALIGN_SPLIT_EN
      ACC1: begin
        if (bus.mem_ready) begin
          n_wait  = '0;
          n_state = DONE;
          n_done  = 1'b1;
          n_rdata = r_is_load ? f_extend({bus.mem_rdata, r_lo}, r_off, r_be, r_zext) : 32'h0;
        end else if (r_wait == c_wait_max) begin
          n_state   = DONE;
          n_done    = 1'b1;
          n_bus_err = 1'b1;
          n_wait    = '0;
        end else begin
          n_wait    = r_wait + 1'b1;
          n_mem_req = 1'b1;
        end
      end
`endif

      DONE: begin
        // Upstream advances on done; a request seen now is not accepted
        n_state = IDLE;
      end

      default: begin
        n_state = IDLE;
      end
    endcase
  end

  // State, context and output registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= IDLE;
      r_is_load   <= 1'b0;
      r_be        <= 4'h0;
      r_zext      <= 1'b0;
      r_off       <= 2'b00;
      r_wait      <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 32'h0;
      r_mem_be    <= 4'h0;
      r_mem_wdata <= 32'h0;
      r_done      <= 1'b0;
      r_rdata     <= 32'h0;
      r_bus_err   <= 1'b0;
      r_misalign  <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
      r_be_hi     <= 4'h0;
      r_wdata_hi  <= 32'h0;
      r_lo        <= 32'h0;
`endif
    end else begin
      r_state     <= n_state;
      r_is_load   <= n_is_load;
      r_be        <= n_be;
      r_zext      <= n_zext;
      r_off       <= n_off;
      r_wait      <= n_wait;
      r_mem_req   <= n_mem_req;
      r_mem_we    <= n_mem_we;
      r_mem_addr  <= n_mem_addr;
      r_mem_be    <= n_mem_be;
      r_mem_wdata <= n_mem_wdata;
      r_done      <= n_done;
      r_rdata     <= n_rdata;
      r_bus_err   <= n_bus_err;
      r_misalign  <= n_misalign;
`ifdef LSU_MISALIGN_SPLIT_EN
      r_be_hi     <= n_be_hi;
      r_wdata_hi  <= n_wdata_hi;
      r_lo        <= n_lo;
`endif
    end
  end

  assign bus.mem_req      = r_mem_req;
  assign bus.mem_we       = r_mem_we;
  assign bus.mem_addr     = r_mem_addr;
  assign bus.mem_be       = r_mem_be;
  assign bus.mem_wdata    = r_mem_wdata;
  assign bus.done         = r_done;
  assign bus.rdata        = r_rdata;
  assign bus.bus_err      = r_bus_err;
  assign bus.misalign_err = r_misalign;
  // Combinational so the pipeline freezes in the same cycle the request shows
  assign bus.stall        = w_start | (r_state == ACC0) | (r_state == ACC1);

endmodule
`default_nettype wire

// File: doc/lsu_mem_port.md
Name: lsu_mem_port

Overview:
- Memory-side responder for the decoded load/store controls MemRead, MemWrite, BE[3:0] and funct3.
- Turns one EX/MEM-stage load/store into one or two word-aligned data-memory beats over a req/ready handshake. Aligns store data onto byte lanes and sign/zero-extends load data.
- Holds the pipeline stalled until the access completes.
- Sits between the EX/MEM pipeline register and the data memory.

Parameters:
- MAX_WAIT, 15, max cycles a beat may wait for mem_ready before abort; counter width is clog2(MAX_WAIT+1).

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  asynchronous, active-high reset.
- MemRead  input  1  load request (EX/MEM).
- MemWrite  input  1  store request (EX/MEM). MemRead and MemWrite are never both 1.
- BE  input  4  size mask: 0001 byte, 0011 half, 1111 word; any other value is illegal.
- funct3  input  3  bit 2 = 1 selects zero-extend on loads.
- addr  input  32  byte address (ALU result).
- wdata  input  32  store data, right-justified.
- mem_req  output  1  beat request.
- mem_we  output  1  1 = write beat.
- mem_addr  output  32  word-aligned address; bits [1:0] are always 0.
- mem_be  output  4  lane enables for the beat.
- mem_wdata  output  32  lane-aligned write data.
- mem_ready  input  1  beat completes this cycle; mem_rdata is valid on this cycle.
- mem_rdata  input  32  read data.
- stall  output  1  freeze upstream pipeline.
- done  output  1  one-cycle completion pulse.
- rdata  output  32  extended load result; valid while done=1.
- bus_err  output  1  one-cycle pulse on timeout abort.
- misalign_err  output  1  one-cycle pulse; see Optional Feature.

Behaviour:
- Reset (async, RST=1): state IDLE. mem_req, mem_we, stall, done, bus_err and misalign_err are 0. mem_addr, mem_be, mem_wdata and rdata are 0. Wait counter is 0. Reset mid-access abandons the beat immediately, with no done and no error pulse.
- Definitions: start = (MemRead|MemWrite) while in IDLE. off = addr[1:0]. lanes[7:0] = BE << off. split = |lanes[7:4].
- stall = start | (state is ACC0 or ACC1). stall is combinational, so it asserts in the same cycle the request appears.
- IDLE:
  - On start, latch MemRead, BE, funct3[2], addr, wdata<<(8*off) as a 64-bit value, and lanes, then go to ACC0.
  - Inputs are ignored in every other state.
- ACC0:
  - Outputs: mem_req=1, mem_we=latched MemWrite, mem_addr={addr[31:2],2'b00}, mem_be=lanes[3:0], mem_wdata=shifted[31:0].
  - On mem_ready: capture mem_rdata into lo. Go to ACC1 if split, else DONE.
- ACC1:
  - Outputs: mem_addr = ACC0 address + 4, wrapping modulo 2^32. mem_be=lanes[7:4], mem_wdata=shifted[63:32].
  - On mem_ready: capture mem_rdata into hi, go to DONE.
- Outputs are registered and held stable while mem_ready=0.
- DONE:
  - done=1 for exactly one cycle, stall=0.
  - For loads, rdata = extend(({hi,lo} >> 8*off) masked by BE). Extension uses bit 7 for BE=0001 and bit 15 for BE=0011; it is zero when funct3[2]=1. For BE=1111 the word passes through.
  - For stores, rdata=0.
  - Next state is IDLE.
- Latency: an aligned access with mem_ready tied high completes in 3 cycles (start, ACC0, DONE); a split access takes 4.
- Timeout:
  - The wait counter increments each ACC cycle with mem_ready=0 and clears on mem_ready or on entering a new beat.
  - When the counter reaches MAX_WAIT with mem_ready still 0, on the next edge: mem_req=0, bus_err=1 for one cycle, done=1 that cycle with rdata=0, state returns to IDLE.
- mem_ready is ignored while mem_req=0.
- A request present in the DONE cycle is not accepted. Upstream must advance on done, and start is re-evaluated in IDLE on the following cycle.

Optional Feature:
- Macro: LSU_MISALIGN_SPLIT_EN.
- Defined: split accesses behave as above, with two beats.
- Undefined: when start occurs with split=1, no beat is issued. FSM goes IDLE -> DONE with misalign_err=1 and done=1 in the same cycle, and rdata=0. ACC1 is not synthesized.
- Aligned accesses are identical in both builds.

Test Plan:
- Aligned LW, addr=0x100, mem_ready=1, mem_rdata=0xDEADBEEF -> mem_addr=0x100, mem_be=1111; done in cycle 3 with rdata=0xDEADBEEF; stall high for cycles 1-2.
- LB, addr=0x103, funct3=000, rdata=0x80000000 -> mem_be=1000, rdata=0xFFFFFF80. Same access with LBU (funct3=100) -> rdata=0x00000080.
- SH, addr=0x206, wdata=0x0000ABCD -> one beat: mem_addr=0x204, mem_be=1100, mem_wdata=0xABCD0000, mem_we=1, done in cycle 3.
- With split enabled: LW at addr=0x1FE, beat0 rdata=0x2211xxxx, beat1 rdata=0xxxxx4433 -> beats at 0x1FC (be=1100) and 0x200 (be=0011); rdata=0x44332211; done in cycle 4. With split disabled: misalign_err=1, no mem_req.
- mem_ready held 0 with MAX_WAIT=15 -> bus_err pulse and done after 16 wait cycles; mem_req drops; next request proceeds normally.
- RST asserted during ACC0 of a store -> mem_req=0 immediately, no done; after release, IDLE accepts a new LW normally.
